imu_bias_filter: RTL

Downstream consumer of the MPU6050 I2C reader. Samples the six raw 16-bit accel/gyro words on a fixed internal sample tick once sensor init completes. Estimates gyro zero-rate bias by averaging a fixed-length calibration window, then emits bias-corrected, optionally IIR-smoothed, signed 16-bit samples with a one-cycle valid strobe. This feeds the attitude estimator.

---
 rtl/imu_bias_filter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/imu_bias_filter.sv
// Gyro zero-rate bias estimator and sample conditioner for the MPU6050 reader.
// Define IMU_IIR_EN to compile the first-order IIR smoothing stage on all six channels.
module imu_bias_filter #(
  parameter int SAMPLE_DIV  = 1000000,
  parameter int CAL_LOG2    = 6,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic [15:0] acc_x,
  input  logic [15:0] acc_y,
  input  logic [15:0] acc_z,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  output logic [15:0] acc_x_f,
  output logic [15:0] acc_y_f,
  output logic [15:0] acc_z_f,
  output logic [15:0] gyro_x_f,
  output logic [15:0] gyro_y_f,
  output logic [15:0] gyro_z_f,
  output logic        out_valid,
  output logic        cal_done,
  output logic [1:0]  state_dbg
);

  // out_valid is a one-cycle strobe qualifying the *_f words; there is no back-pressure.
  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int AW = 16 + CAL_LOG2;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [CAL_LOG2-1:0] CAL_LAST = '1;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CALIB = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic                 samp_pend;
  logic [15:0]          raw      [6];
  logic [15:0]          samp     [6];
  logic [15:0]          x        [6];
  logic [15:0]          y        [6];
  logic [15:0]          y_nxt    [6];
  logic signed [AW-1:0] accum    [3];
  logic signed [AW-1:0] accum_sum[3];
  logic [15:0]          bias     [3];
  logic [15:0]          bias_nxt [3];
  logic signed [16:0]   gdiff    [3];
  logic [CAL_LOG2-1:0]  cal_cnt;
  logic                 acc_en, run_en, abort, cal_finish;

  assign tick      = (tick_cnt == TICK_LAST);
  assign state_dbg = state;

  always_comb begin
    raw[0] = acc_x;
    raw[1] = acc_y;
    raw[2] = acc_z;
    raw[3] = gyro_x;
    raw[4] = gyro_y;
    raw[5] = gyro_z;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_nxt;
  end

  // Losing init_done always wins over a pending calibration step or output update.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_WAIT:  if (tick && init_done) state_nxt = ST_CALIB;
      ST_CALIB: if (!init_done) state_nxt = ST_WAIT;
                else if (samp_pend && cal_cnt == CAL_LAST) state_nxt = ST_RUN;
      ST_RUN:   if (!init_done) state_nxt = ST_WAIT;
      default:  state_nxt = ST_WAIT;
    endcase
  end

  always_comb begin
    acc_en   = 1'b0;
    run_en   = 1'b0;
    abort    = 1'b0;
    cal_done = 1'b0;
    unique case (state)
      ST_CALIB: begin
        abort  = !init_done;
        acc_en = init_done && samp_pend;
      end
      ST_RUN: begin
        cal_done = 1'b1;
        abort    = !init_done;
        run_en   = init_done && samp_pend;
      end
      default: ;
    endcase
  end

  assign cal_finish = acc_en && (cal_cnt == CAL_LAST);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      x[i]     = samp[i];
      gdiff[i] = {samp[3+i][15], samp[3+i]} - {bias[i][15], bias[i]};
      if (gdiff[i][16] != gdiff[i][15]) x[3+i] = gdiff[i][16] ? 16'h8000 : 16'h7fff;
      else                              x[3+i] = gdiff[i][15:0];
      accum_sum[i] = accum[i] + AW'($signed(samp[3+i]));
      bias_nxt[i]  = 16'(accum_sum[i] >>> CAL_LOG2);
    end
  end

`ifdef IMU_IIR_EN
  logic               first;
  logic signed [16:0] fdiff[6];
  logic [15:0]        fstep[6];

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      fdiff[i] = {x[i][15], x[i]} - {y[i][15], y[i]};
      fstep[i] = 16'(fdiff[i] >>> ALPHA_SHIFT);
      // The step never overshoots x, so 16-bit wraparound addition is exact.
      y_nxt[i] = first ? x[i] : y[i] + fstep[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort)    first <= 1'b0;
    else if (cal_finish) first <= 1'b1;
    else if (run_en)     first <= 1'b0;
  end
`else
  always_comb begin
    for (int i = 0; i < 6; i++) y_nxt[i] = x[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt  <= '0;
      samp_pend <= 1'b0;
      out_valid <= 1'b0;
      cal_cnt   <= '0;
      for (int i = 0; i < 6; i++) begin
        samp[i] <= '0;
        y[i]    <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        accum[i] <= '0;
        bias[i]  <= '0;
      end
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
      samp_pend <= tick;
      out_valid <= run_en;
      if (tick) begin
        for (int i = 0; i < 6; i++) samp[i] <= raw[i];
      end
      if (abort) begin
        cal_cnt <= '0;
        for (int i = 0; i < 3; i++) begin
          accum[i] <= '0;
          bias[i]  <= '0;
        end
      end else if (acc_en) begin
        cal_cnt <= cal_cnt + 1'b1;
        for (int i = 0; i < 3; i++) begin
          if (cal_finish) begin
            bias[i]  <= bias_nxt[i];
            accum[i] <= '0;
          end else begin
            accum[i] <= accum_sum[i];
          end
        end
      end else if (run_en) begin
        for (int i = 0; i < 6; i++) y[i] <= y_nxt[i];
      end
    end
  end

  assign acc_x_f  = y[0];
  assign acc_y_f  = y[1];
  assign acc_z_f  = y[2];
  assign gyro_x_f = y[3];
  assign gyro_y_f = y[4];
  assign gyro_z_f = y[5];

endmodule
